multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle LEGv8 control FSM; successor to the single-cycle combinational decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives datapath enables.
//  Handshakes with a variable-latency memory via mem_req/mem_ready, with a bounded wait.
//  Decodes R-format, LDUR, STUR, CBZ and CBNZ; unknown opcodes trap.
// PARAMETERS
//  OP_W        11  opcode field width; the upper 11 bits of the instruction word
//  TIMEOUT_W   4   width of the memory wait counter
//  MEM_TIMEOUT 15  cycles to wait for mem_ready before trapping; must be < 2**TIMEOUT_W
// PORTS
//  clk           in   1     rising-edge clock
//  reset         in   1     synchronous, active-high
//  op            in   OP_W  IR[31:21]; valid from DECODE onward
//  mem_ready     in   1     memory completes the current mem_req beat
//  state         out  3     current FSM state, for debug
//  pc_write      out  1     load PC+4 (FETCH)
//  ir_write      out  1     load IR from memory read data
//  mem_req       out  1     memory access request; held until mem_ready
//  mem_we        out  1     1 = write (STUR); qualified by mem_req
//  mem_addr_sel  out  1     0 = PC, 1 = ALU result
//  alu_op        out  2     00 = add, 01 = pass B / zero-test, 10 = R-format funct
//  alu_src       out  1     1 = sign-extended immediate operand
//  branch        out  1     conditional branch evaluate; one cycle in EXEC
//  branch_nz     out  1     1 = CBNZ sense (branch when not zero)
//  reg_write     out  1     register-file write; one cycle in WB
//  mem_to_reg    out  1     writeback source: 1 = memory data, 0 = ALU
//  illegal       out  1     sticky: undecodable opcode
//  timeout       out  1     sticky: mem_ready not seen within MEM_TIMEOUT cycles
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. All outputs are Moore,
//   decoded from state plus a class register latched in DECODE.
//  Reset: state=FETCH; class=NONE; wait counter=0; illegal=0; timeout=0.
//   All enables are 0 during the reset cycle. Reset mid-access drops mem_req the next cycle.
//  FETCH: mem_req=1, mem_addr_sel=0. On mem_ready, pulse ir_write and pc_write for that cycle,
//   then go to DECODE. A zero-wait fetch takes 1 cycle.
//  DECODE: latch class from op. Classes (x = don't care):
//   R    = 10001011000, 11001011000, 10001010000, 10101010000
//   LDUR = 11111000010
//   STUR = 11111000000
//   CBZ  = 10110100xxx
//   CBNZ = 10110101xxx
//   Anything else -> TRAP with illegal=1.
//  EXEC by class:
//   R:        alu_op=10, alu_src=0 -> WB
//   LDUR/STUR: alu_op=00, alu_src=1 -> MEM
//   CBZ/CBNZ: alu_op=01, branch=1, branch_nz=(CBNZ) -> FETCH. Instruction done.
//  MEM: mem_req=1, mem_addr_sel=1, mem_we=(STUR). On mem_ready: LDUR -> WB, STUR -> FETCH.
//  WB: reg_write=1 for one cycle; mem_to_reg=(LDUR) -> FETCH.
//  Cycle counts at zero wait: R 4, LDUR 5, STUR 4, CBZ/CBNZ 3.
//  Wait counter: cleared on entry to FETCH or MEM and whenever mem_ready=1; increments each
//   cycle mem_req=1 and mem_ready=0, and saturates.
//  When counter == MEM_TIMEOUT with mem_ready=0 -> TRAP, timeout=1.
//   If mem_ready=1 arrives in that same cycle, it wins and no trap occurs.
//  TRAP: all enables 0, mem_req=0. Held until reset; illegal and timeout stay sticky.
//  mem_ready outside FETCH/MEM is ignored.
// CONFIGURATION
//  CTRL_UNCOND_B_EN defined: adds class B = 000101xxxxx.
//   EXEC: uncond_branch=1 (extra 1-bit output port) -> FETCH; 3 cycles.
//  CTRL_UNCOND_B_EN undefined: no uncond_branch port; 000101xxxxx traps as illegal.
// TESTING
//  Reset, op=ADD 10001011000, mem_ready=1 always -> states 0,1,2,4,0; reg_write high
//   only in WB; alu_op=10.
//  LDUR 11111000010, fetch ready at cycle 0, data ready after 3 waits -> MEM held 4 cycles
//   with mem_req=1, mem_addr_sel=1, mem_we=0; then WB with mem_to_reg=1.
//  STUR 11111000000 -> MEM has mem_we=1; returns to FETCH; reg_write never asserted.
//  CBZ 10110100101 then CBNZ 10110101000 -> branch=1 in EXEC, branch_nz = 0 then 1;
//   3 cycles each.
//  mem_ready held 0 in FETCH -> TRAP after 15 wait cycles, timeout=1, mem_req=0; reset
//   returns FETCH with flags cleared. Also ready on cycle 15 exactly -> no trap.
//  op=00000000000 -> TRAP, illegal=1. With CTRL_UNCOND_B_EN, op=00010100000 ->
//   uncond_branch=1 in EXEC, no trap.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle controller (master) and memory (slave).
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with a bounded memory wait.
// Define CTRL_UNCOND_B_EN to add the unconditional B class and the uncond_branch output.
module multicycle_control #(
  parameter int unsigned OP_W        = 11,
  parameter int unsigned TIMEOUT_W   = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op,
  multicycle_control_if.master mem,
  output logic [2:0]           state,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic [1:0]           alu_op,
  output logic                 alu_src,
  output logic                 branch,
  output logic                 branch_nz,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic                 timeout
`ifdef CTRL_UNCOND_B_EN
  ,
  output logic                 uncond_branch
`endif
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StTrap   = 3'd7;

  localparam logic [2:0] ClsNone = 3'd0;
  localparam logic [2:0] ClsR    = 3'd1;
  localparam logic [2:0] ClsLdur = 3'd2;
  localparam logic [2:0] ClsStur = 3'd3;
  localparam logic [2:0] ClsCbz  = 3'd4;
  localparam logic [2:0] ClsCbnz = 3'd5;
  localparam logic [2:0] ClsB    = 3'd6;

  localparam logic [TIMEOUT_W-1:0] TimeoutVal = TIMEOUT_W'(MEM_TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] CntMax     = '1;

  logic [2:0]           stateQ, stateD;
  logic [2:0]           classQ, classD, classDec;
  logic [TIMEOUT_W-1:0] cntQ, cntD;
  logic                 illegalQ, illegalD;
  logic                 timeoutQ, timeoutD;
  logic [10:0]          opTop;
  logic                 memReady;
  logic                 reqInt;

  assign opTop    = op[OP_W-1 -: 11];
  assign memReady = mem.mem_ready;
  assign reqInt   = (stateQ == StFetch) || (stateQ == StMem);

  always_comb begin
    classDec = ClsNone;
    casez (opTop)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: classDec = ClsR;
      11'b11111000010: classDec = ClsLdur;
      11'b11111000000: classDec = ClsStur;
      11'b10110100???: classDec = ClsCbz;
      11'b10110101???: classDec = ClsCbnz;
`ifdef CTRL_UNCOND_B_EN
      11'b000101?????: classDec = ClsB;
`endif
      default:         classDec = ClsNone;
    endcase
  end

  always_comb begin
    stateD   = stateQ;
    classD   = classQ;
    illegalD = illegalQ;
    timeoutD = timeoutQ;
    case (stateQ)
      StFetch: begin
        if (memReady) begin
          stateD = StDecode;
        end else if (cntQ == TimeoutVal) begin
          stateD   = StTrap;
          timeoutD = 1'b1;
        end
      end
      StDecode: begin
        classD = classDec;
        if (classDec == ClsNone) begin
          stateD   = StTrap;
          illegalD = 1'b1;
        end else begin
          stateD = StExec;
        end
      end
      StExec: begin
        case (classQ)
          ClsR:                   stateD = StWb;
          ClsLdur, ClsStur:       stateD = StMem;
          ClsCbz, ClsCbnz, ClsB:  stateD = StFetch;
          default:                stateD = StTrap;
        endcase
      end
      StMem: begin
        if (memReady) begin
          stateD = (classQ == ClsLdur) ? StWb : StFetch;
        end else if (cntQ == TimeoutVal) begin
          stateD   = StTrap;
          timeoutD = 1'b1;
        end
      end
      StWb:    stateD = StFetch;
      StTrap:  stateD = StTrap;
      default: stateD = StTrap;
    endcase
  end

  // Any state change (including entry to FETCH/MEM) restarts the wait count.
  always_comb begin
    cntD = cntQ;
    if ((stateD != stateQ) || memReady) begin
      cntD = '0;
    end else if (reqInt && (cntQ != CntMax)) begin
      cntD = cntQ + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StFetch;
      classQ   <= ClsNone;
      cntQ     <= '0;
      illegalQ <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      classQ   <= classD;
      cntQ     <= cntD;
      illegalQ <= illegalD;
      timeoutQ <= timeoutD;
    end
  end

  // Enables are forced low while reset is asserted so an in-flight access is abandoned.
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    alu_op           = 2'b00;
    alu_src          = 1'b0;
    branch           = 1'b0;
    branch_nz        = 1'b0;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
`ifdef CTRL_UNCOND_B_EN
    uncond_branch    = 1'b0;
`endif
    if (!reset) begin
      case (stateQ)
        StFetch: begin
          mem.mem_req = 1'b1;
          pc_write    = memReady;
          ir_write    = memReady;
        end
        StExec: begin
          case (classQ)
            ClsR:    alu_op = 2'b10;
            ClsLdur,
            ClsStur: alu_src = 1'b1;
            ClsCbz: begin
              alu_op = 2'b01;
              branch = 1'b1;
            end
            ClsCbnz: begin
              alu_op    = 2'b01;
              branch    = 1'b1;
              branch_nz = 1'b1;
            end
`ifdef CTRL_UNCOND_B_EN
            ClsB:    uncond_branch = 1'b1;
`endif
            default: ;
          endcase
        end
        StMem: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (classQ == ClsStur);
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = (classQ == ClsLdur);
        end
        default: ;
      endcase
    end
  end

  assign state   = stateQ;
  assign illegal = illegalQ;
  assign timeout = timeoutQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus timeout/reset sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] op;
  logic [2:0]  state;
  logic        pc_write, ir_write, alu_src, branch, branch_nz;
  logic        reg_write, mem_to_reg, illegal, timeout;
  logic [1:0]  alu_op;
`ifdef CTRL_UNCOND_B_EN
  logic        uncond_branch;
`endif

  multicycle_control_if memIf ();

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .mem          (memIf),
    .state        (state),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .alu_op       (alu_op),
    .alu_src      (alu_src),
    .branch       (branch),
    .branch_nz    (branch_nz),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .illegal      (illegal),
    .timeout      (timeout)
`ifdef CTRL_UNCOND_B_EN
    ,
    .uncond_branch(uncond_branch)
`endif
  );

  always #5 clk = ~clk;

  // {pc_write,ir_write}_{req,we,addr_sel}_{alu_op}_{alu_src,branch,branch_nz}_{rw,m2r}_{ill,to}
  localparam logic [13:0] CIdle      = 14'b00_000_00_000_00_00;
  localparam logic [13:0] CFetchRdy  = 14'b11_100_00_000_00_00;
  localparam logic [13:0] CFetchWait = 14'b00_100_00_000_00_00;
  localparam logic [13:0] CExecR     = 14'b00_000_10_000_00_00;
  localparam logic [13:0] CExecMem   = 14'b00_000_00_100_00_00;
  localparam logic [13:0] CMemLd     = 14'b00_101_00_000_00_00;
  localparam logic [13:0] CMemSt     = 14'b00_111_00_000_00_00;
  localparam logic [13:0] CWbR       = 14'b00_000_00_000_10_00;
  localparam logic [13:0] CWbLd      = 14'b00_000_00_000_11_00;
  localparam logic [13:0] CCbz       = 14'b00_000_01_010_00_00;
  localparam logic [13:0] CCbnz      = 14'b00_000_01_011_00_00;
  localparam logic [13:0] CTrapIll   = 14'b00_000_00_000_00_10;

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpCbz  = 11'b10110100101;
  localparam logic [10:0] OpCbnz = 11'b10110101000;
  localparam logic [10:0] OpBad  = 11'b00000000000;
  localparam logic [10:0] OpB    = 11'b00010100000;

  typedef struct {
    logic        rst;
    logic [10:0] op;
    logic        rdy;
    logic [2:0]  st;
    logic [13:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   nChecks = 0;
  int   nErrors = 0;

  logic [13:0] actCtl;
  assign actCtl = {pc_write, ir_write, memIf.mem_req, memIf.mem_we, memIf.mem_addr_sel,
                   alu_op, alu_src, branch, branch_nz, reg_write, mem_to_reg, illegal, timeout};

  function automatic void add(input logic r, input logic [10:0] o, input logic rdy,
                              input logic [2:0] st, input logic [13:0] ctl);
    vec_t v;
    v.rst = r;
    v.op  = o;
    v.rdy = rdy;
    v.st  = st;
    v.ctl = ctl;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Drive inputs mid-low-phase, then let combinational outputs settle before the next edge.
  task automatic step(input logic r, input logic [10:0] o, input logic rdy);
    @(negedge clk);
    reset           = r;
    op              = o;
    memIf.mem_ready = rdy;
    #2;
  endtask

  initial begin
    reset           = 1'b1;
    op              = OpAdd;
    memIf.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    add(1, OpAdd,  1, 3'd0, CIdle);
    add(0, OpAdd,  1, 3'd0, CFetchRdy);
    add(0, OpAdd,  1, 3'd1, CIdle);
    add(0, OpAdd,  1, 3'd2, CExecR);
    add(0, OpAdd,  1, 3'd4, CWbR);
    add(0, OpLdur, 1, 3'd0, CFetchRdy);
    add(0, OpLdur, 1, 3'd1, CIdle);
    add(0, OpLdur, 0, 3'd2, CExecMem);
    add(0, OpLdur, 0, 3'd3, CMemLd);
    add(0, OpLdur, 0, 3'd3, CMemLd);
    add(0, OpLdur, 0, 3'd3, CMemLd);
    add(0, OpLdur, 1, 3'd3, CMemLd);
    add(0, OpLdur, 0, 3'd4, CWbLd);
    add(0, OpStur, 1, 3'd0, CFetchRdy);
    add(0, OpStur, 0, 3'd1, CIdle);
    add(0, OpStur, 0, 3'd2, CExecMem);
    add(0, OpStur, 1, 3'd3, CMemSt);
    add(0, OpCbz,  1, 3'd0, CFetchRdy);
    add(0, OpCbz,  1, 3'd1, CIdle);
    add(0, OpCbz,  1, 3'd2, CCbz);
    add(0, OpCbnz, 1, 3'd0, CFetchRdy);
    add(0, OpCbnz, 0, 3'd1, CIdle);
    add(0, OpCbnz, 0, 3'd2, CCbnz);
    add(0, OpBad,  0, 3'd0, CFetchWait);
    add(0, OpBad,  1, 3'd0, CFetchRdy);
    add(0, OpBad,  1, 3'd1, CIdle);
    add(0, OpBad,  1, 3'd7, CTrapIll);
    add(0, OpBad,  0, 3'd7, CTrapIll);
    add(1, OpBad,  0, 3'd7, CTrapIll);
    add(0, OpAdd,  0, 3'd0, CFetchWait);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].rdy);
      check($sformatf("row%0d_state", i), 16'(state), 16'(tbl[i].st));
      check($sformatf("row%0d_ctl", i), 16'(actCtl), 16'(tbl[i].ctl));
    end

    // Fetch never answered: 15 counted waits, trap taken at the 16th FETCH cycle.
    step(1, OpAdd, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, OpAdd, 0);
      check($sformatf("to_wait%0d_state", i), 16'(state), 16'd0);
      check($sformatf("to_wait%0d_req", i), 16'(memIf.mem_req), 16'd1);
    end
    step(0, OpAdd, 1);
    check("to_trap_state", 16'(state), 16'd7);
    check("to_trap_flag", 16'(timeout), 16'd1);
    check("to_trap_req", 16'(memIf.mem_req), 16'd0);
    check("to_trap_irw", 16'(ir_write), 16'd0);
    step(1, OpAdd, 0);
    check("to_rst_en", 16'(memIf.mem_req), 16'd0);
    step(0, OpAdd, 0);
    check("to_clr_state", 16'(state), 16'd0);
    check("to_clr_flags", 16'({illegal, timeout}), 16'd0);

    // Ready arriving on the boundary cycle wins over the trap.
    step(1, OpAdd, 0);
    for (int i = 0; i < 15; i++) step(0, OpAdd, 0);
    step(0, OpAdd, 1);
    check("edge_irw", 16'(ir_write), 16'd1);
    step(0, OpAdd, 0);
    check("edge_state", 16'(state), 16'd1);
    check("edge_flag", 16'(timeout), 16'd0);

    // Reset in the middle of a data access drops the request.
    step(1, OpLdur, 0);
    step(0, OpLdur, 1);
    step(0, OpLdur, 0);
    step(0, OpLdur, 0);
    step(0, OpLdur, 0);
    check("mid_mem_req", 16'({memIf.mem_req, memIf.mem_addr_sel}), 16'b11);
    step(1, OpLdur, 0);
    check("mid_rst_req", 16'(memIf.mem_req), 16'd0);
    step(0, OpLdur, 0);
    check("mid_rst_state", 16'(state), 16'd0);

    // Unconditional branch class: decoded only when the option is built in.
    step(1, OpB, 0);
    step(0, OpB, 1);
    step(0, OpB, 0);
    step(0, OpB, 0);
`ifdef CTRL_UNCOND_B_EN
    check("b_exec_state", 16'(state), 16'd2);
    check("b_uncond", 16'(uncond_branch), 16'd1);
    step(0, OpB, 0);
    check("b_done_state", 16'(state), 16'd0);
    check("b_no_trap", 16'(illegal), 16'd0);
`else
    check("b_trap_state", 16'(state), 16'd7);
    check("b_trap_flag", 16'(illegal), 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
